axil_counter_reader: RTL and testbench

AXI4-Lite initiator that drives the register port of the 64-bit free-running counter block (and any other 12-bit-address, 64-bit-data AXI4-Lite responder in the design). A simple command interface issues one read or write at a time. The block runs the AR/R or AW/W/B handshakes and returns one response pulse with data, response code and a timeout flag. It sits on the `aclk` side, between control logic or a debug/monitor FSM and the counter's AXI4-Lite slave port.

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_timeout_timer.sv | 24 ++
 rtl/axil_counter_reader.sv | 194 +++++++++++++++++++
 tb/tb_axil_counter_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite initiator types: FSM state encoding and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Timeouts reuse the DECERR encoding; rsp_timeout tells them apart.
  localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

endpackage

// File: rtl/axil_timeout_timer.sv
// Saturating response-wait counter; expired once TIMEOUT_CYCLES wait cycles have elapsed.
module axil_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge aclk) begin
    if (areset || i_clear) r_cnt <= '0;
    else if (i_enable && (r_cnt != LIMIT)) r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/axil_counter_reader.sv
// Single-outstanding AXI4-Lite initiator: one command in, one response pulse out,
// with a response-wait timeout and a drain state that swallows the late beat.
module axil_counter_reader
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [1:0]              rresp,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp
);

  state_e                  r_state;
  logic                    r_is_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic r_cmd_ready, r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic r_rsp_valid, r_rsp_timeout;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [1:0]              r_rsp_resp;

  logic w_waiting, w_expired;
  assign w_waiting = (r_state == ST_RD_DATA) || (r_state == ST_WR_RESP);

  axil_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .aclk      (aclk),
    .areset    (areset),
    .i_clear   (!w_waiting),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_is_wr       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_cmd_ready   <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_is_wr     <= cmd_write;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // A beat arriving on the expiry cycle still wins over the timeout.
          if (rvalid) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= rdata;
            r_rsp_resp    <= rresp;
            r_state       <= ST_DONE;
          end else if (w_expired) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_resp    <= RESP_TIMEOUT;
            r_state       <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if ((awready || !r_awvalid) && (wready || !r_wvalid)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= bresp;
            r_state       <= ST_DONE;
          end else if (w_expired) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_resp    <= RESP_TIMEOUT;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rsp_valid   <= 1'b0;
          r_rsp_timeout <= 1'b0;
          if (r_rsp_timeout) begin
            r_rready <= !r_is_wr;
            r_bready <= r_is_wr;
            r_state  <= ST_DRAIN;
          end else begin
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if ((r_rready && rvalid) || (r_bready && bvalid)) begin
            r_rready    <= 1'b0;
            r_bready    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;
  assign arvalid     = r_arvalid;
  assign araddr      = r_addr;
  assign arprot      = 3'b000;
  assign rready      = r_rready;
  assign awvalid     = r_awvalid;
  assign awaddr      = r_addr;
  assign awprot      = 3'b000;
  assign wvalid      = r_wvalid;
  assign wdata       = r_wdata;
  assign wstrb       = r_wstrb;
  assign bready      = r_bready;

endmodule

// File: tb/tb_axil_counter_reader.sv
// Bench: delay-programmable AXI4-Lite responder plus a memory/latency reference model.
module tb_axil_counter_reader;
  localparam int TO = 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid, rsp_timeout;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] araddr, awaddr;
  logic [2:0]  arprot, awprot;
  logic [1:0]  rresp, bresp;
  logic [63:0] rdata, wdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  axil_counter_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 aclk = ~aclk;

  // responder configuration and state
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [1:0]  rresp_cfg, bresp_cfg;
  logic [63:0] slv_mem [512];
  logic [63:0] ref_mem [512];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_go, r_go, aw_go, w_go, b_go, r_pend, b_pend, aw_done, w_done;
    logic [11:0] s_araddr, s_awaddr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    {ar_go, r_go, aw_go, w_go, b_go, r_pend, b_pend, aw_done, w_done} = '0;
    s_araddr = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        {ar_go, r_go, aw_go, w_go, b_go, r_pend, b_pend, aw_done, w_done} = '0;
      end else begin
        // retire handshakes that completed at the last rising edge
        if (ar_go) begin arready = 0; ar_go = 0; r_pend = 1; r_cnt = 0; end
        if (r_go)  begin rvalid = 0; r_go = 0; end
        if (aw_go) begin awready = 0; aw_go = 0; aw_done = 1; end
        if (w_go)  begin wready = 0; w_go = 0; w_done = 1; end
        if (b_go)  begin bvalid = 0; b_go = 0; end
        if (aw_done && w_done) begin
          slv_mem[s_awaddr[11:3]] = merge(slv_mem[s_awaddr[11:3]], s_wdata, s_wstrb);
          aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
        end
        if (arvalid && !arready) begin
          if (ar_cnt == ar_dly) begin arready = 1; ar_go = 1; ar_cnt = 0; s_araddr = araddr; end
          else ar_cnt++;
        end
        if (awvalid && !awready) begin
          if (aw_cnt == aw_dly) begin awready = 1; aw_go = 1; aw_cnt = 0; s_awaddr = awaddr; end
          else aw_cnt++;
        end
        if (wvalid && !wready) begin
          if (w_cnt == w_dly) begin wready = 1; w_go = 1; w_cnt = 0; s_wdata = wdata; s_wstrb = wstrb; end
          else w_cnt++;
        end
        if (r_pend && !rvalid) begin
          if (r_cnt == r_dly) begin rvalid = 1; rdata = slv_mem[s_araddr[11:3]]; rresp = rresp_cfg; r_pend = 0; end
          else r_cnt++;
        end
        if (b_pend && !bvalid) begin
          if (b_cnt == b_dly) begin bvalid = 1; bresp = bresp_cfg; b_pend = 0; end
          else b_cnt++;
        end
        if (rvalid && rready) r_go = 1;
        if (bvalid && bready) b_go = 1;
      end
    end
  end

  task automatic wait_ready();
    int n;
    for (n = 0; n < 100; n++) begin
      if (cmd_ready) break;
      @(negedge aclk);
    end
    if (n == 100) chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
  endtask

  // One command; d1/d2 = AR (or AW/W) ready delays, d = R/B delay in the response-wait state.
  task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [63:0] wd,
                         input logic [7:0] ws, input int d1, input int d2, input int d,
                         input logic [1:0] rsp);
    int a, exp_pulse, exp_ready, pulse, ready, npulse, arv, awv, wv, bad;
    bit to;
    logic [63:0] exp_data, got_data;
    logic [1:0]  exp_resp, got_resp;
    logic        got_to;
    a  = wr ? ((d1 > d2) ? d1 : d2) : d1;
    to = (d > TO);
    exp_pulse = 3 + a + (to ? TO : d);
    exp_ready = to ? 3 + a + ((d > TO + 1) ? d : TO + 2) : exp_pulse + 1;
    exp_data  = (wr || to) ? 64'd0 : ref_mem[addr[11:3]];
    exp_resp  = to ? 2'b11 : rsp;
    if (wr) ref_mem[addr[11:3]] = merge(ref_mem[addr[11:3]], wd, ws);
    if (wr) begin aw_dly = d1; w_dly = d2; b_dly = d; bresp_cfg = rsp; end
    else    begin ar_dly = d1; r_dly = d; rresp_cfg = rsp; end
    wait_ready();
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    pulse = -1; ready = -1; npulse = 0; arv = 0; awv = 0; wv = 0; bad = 0;
    got_data = 'x; got_resp = 'x; got_to = 'x;
    for (int k = 1; k < 300; k++) begin
      @(negedge aclk);
      if (k == 1) cmd_valid = 0;
      if (arvalid) begin arv++; if (araddr !== addr) bad++; end
      if (awvalid) begin awv++; if (awaddr !== addr) bad++; end
      if (wvalid)  begin wv++;  if (wdata !== wd || wstrb !== ws) bad++; end
      if (arprot !== 3'b000 || awprot !== 3'b000) bad++;
      if (pulse < 0 && cmd_ready) bad++;
      if (rsp_valid) begin
        npulse++;
        if (pulse < 0) begin pulse = k; got_data = rsp_data; got_resp = rsp_resp; got_to = rsp_timeout; end
      end
      if (pulse >= 0 && k > pulse && cmd_ready) begin ready = k; break; end
    end
    chk("pulse_cycle", 64'(pulse), 64'(exp_pulse));
    chk("ready_cycle", 64'(ready), 64'(exp_ready));
    chk("pulse_count", 64'(npulse), 64'd1);
    chk("rsp_data", got_data, exp_data);
    chk("rsp_resp", {62'd0, got_resp}, {62'd0, exp_resp});
    chk("rsp_timeout", {63'd0, got_to}, {63'd0, to});
    chk("rsp_hold", rsp_data, exp_data);
    chk("chan_stable", 64'(bad), 64'd0);
    if (wr) begin
      chk("awvalid_cycles", 64'(awv), 64'(d1 + 1));
      chk("wvalid_cycles", 64'(wv), 64'(d2 + 1));
    end else begin
      chk("arvalid_cycles", 64'(arv), 64'(d1 + 1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    chk({tag, "_valids"}, {58'd0, arvalid, rready, awvalid, wvalid, bready, rsp_valid}, 64'd0);
    chk({tag, "_rsp_timeout"}, {63'd0, rsp_timeout}, 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_resp"}, {62'd0, rsp_resp}, 64'd0);
    chk({tag, "_addr"}, {40'd0, araddr, awaddr}, 64'd0);
    chk({tag, "_wdata"}, wdata, 64'd0);
    chk({tag, "_wstrb"}, {56'd0, wstrb}, 64'd0);
  endtask

  initial begin
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; rresp_cfg = 0; bresp_cfg = 0;
    for (int i = 0; i < 512; i++) begin
      slv_mem[i] = {$urandom, $urandom};
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[0] = 64'h1234; ref_mem[0] = 64'h1234;
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge aclk);
    chk_reset_outputs("reset");
    areset = 0;

    run_txn(0, 12'h000, 64'd0, 8'h00, 0, 0, 0, 2'b00);
    run_txn(1, 12'h008, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 2, 0, 2'b00);
    run_txn(0, 12'h008, 64'd0, 8'h00, 0, 0, 0, 2'b00);
    run_txn(0, 12'h000, 64'd0, 8'h00, 5, 0, 0, 2'b00);
    run_txn(0, 12'h018, 64'd0, 8'h00, 0, 0, 1, 2'b10);
    run_txn(0, 12'h020, 64'd0, 8'h00, 0, 0, 20, 2'b00);
    run_txn(1, 12'h028, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 0, 12, 2'b00);
    run_txn(0, 12'h028, 64'd0, 8'h00, 0, 0, TO, 2'b00);
    run_txn(0, 12'h030, 64'd0, 8'h00, 0, 0, TO + 1, 2'b00);
    run_txn(1, 12'h030, 64'h5555_AAAA_5555_AAAA, 8'hA5, 3, 1, 2, 2'b01);

    // reset while waiting in the read data phase
    wait_ready();
    r_dly = 6; ar_dly = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h040;
    @(negedge aclk); cmd_valid = 0;
    @(negedge aclk);
    chk("mid_rready", {63'd0, rready}, 64'd1);
    areset = 1;
    @(negedge aclk);
    chk_reset_outputs("midrst");
    @(negedge aclk);
    chk("midrst_no_pulse", {63'd0, rsp_valid}, 64'd0);
    areset = 0;
    run_txn(0, 12'h040, 64'd0, 8'h00, 0, 0, 0, 2'b00);

    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [11:0] ad;
      logic [7:0]  st;
      logic [1:0]  rs;
      wr = 1'($urandom_range(0, 1));
      ad = 12'($urandom_range(0, 4095));
      st = 8'($urandom_range(0, 255));
      rs = 2'($urandom_range(0, 3));
      run_txn(wr, ad, {$urandom, $urandom}, st, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 12), rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
